// File: rtl/keypad_emulator.sv
// Passive 4x4 matrix keypad model with LFSR-driven contact bounce.
// Rows respond combinationally to the scanner's column drive through the held key.
module keypad_emulator #(
    parameter int          BOUNCE_CYCLES = 16,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_press,
    input  logic [3:0] cmd_key,
    input  logic [3:0] keypad_vert,
    output logic [3:0] keypad_hori,
    output logic       contact
);

    localparam int         CW       = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
    localparam logic [7:0] SEED     = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [CW-1:0] CNT_LOAD = (BOUNCE_CYCLES > 0) ? CW'(BOUNCE_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        BOUNCE_DN,
        HELD,
        BOUNCE_UP
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    key, key_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [7:0]    lfsr, lfsr_nxt, lfsr_step;
    logic          contact_nxt;
    logic          accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            key     <= '0;
            cnt     <= '0;
            lfsr    <= SEED;
            contact <= 1'b0;
        end else begin
            state   <= state_nxt;
            key     <= key_nxt;
            cnt     <= cnt_nxt;
            lfsr    <= lfsr_nxt;
            contact <= contact_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        key_nxt     = key;
        cnt_nxt     = cnt;
        lfsr_nxt    = lfsr;
        contact_nxt = contact;
        lfsr_step   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        cmd_ready   = (state == IDLE) || (state == HELD);
        accept      = cmd_valid && cmd_ready;

        case (state)
            IDLE: begin
                contact_nxt = 1'b0;
                if (accept && cmd_press) begin
                    key_nxt = cmd_key;
                    cnt_nxt = CNT_LOAD;
                    state_nxt = (BOUNCE_CYCLES == 0) ? HELD : BOUNCE_DN;
                end
            end
            HELD: begin
                // A press while held is consumed but leaves the latched key alone.
                contact_nxt = 1'b1;
                if (accept && !cmd_press) begin
                    cnt_nxt = CNT_LOAD;
                    state_nxt = (BOUNCE_CYCLES == 0) ? IDLE : BOUNCE_UP;
                end
            end
            BOUNCE_DN, BOUNCE_UP: begin
                lfsr_nxt    = lfsr_step;
                contact_nxt = lfsr_step[0];
                if (cnt == '0) begin
                    state_nxt = (state == BOUNCE_DN) ? HELD : IDLE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Matrix is a passive short: only the key's row follows the key's column.
    always_comb begin
        keypad_hori = '1;
        keypad_hori[key[3:2]] = ~(contact && !keypad_vert[key[1:0]]);
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: a 16-cycle bounce instance and a clean-edge instance.
module tb_keypad_emulator;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_press = 1'b0;
    logic [3:0] cmd_key = 4'h0;
    logic       valid1 = 1'b0, valid0 = 1'b0;
    logic       ready1, ready0;
    logic [3:0] vert1 = 4'hF, vert0 = 4'hF;
    logic [3:0] hori1, hori0;
    logic       contact1, contact0;

    int vecs = 0;
    int errs = 0;
    logic [7:0] model = 8'hA5;

    keypad_emulator #(.BOUNCE_CYCLES(16), .LFSR_SEED(8'hA5)) d1 (
        .clk(clk), .reset(reset), .cmd_valid(valid1), .cmd_ready(ready1),
        .cmd_press(cmd_press), .cmd_key(cmd_key), .keypad_vert(vert1),
        .keypad_hori(hori1), .contact(contact1)
    );

    keypad_emulator #(.BOUNCE_CYCLES(0), .LFSR_SEED(8'hA5)) d0 (
        .clk(clk), .reset(reset), .cmd_valid(valid0), .cmd_ready(ready0),
        .cmd_press(cmd_press), .cmd_key(cmd_key), .keypad_vert(vert0),
        .keypad_hori(hori0), .contact(contact0)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int v = 0; v < 16; v++) begin
            vert1 = 4'(v);
            vert0 = 4'(v);
            #1;
            vecs++;
            if (hori1 !== 4'hF) begin errs++; $display("FAIL reset_hori vert=%h: got %h expected f", vert1, hori1); end
            vecs++;
            if (ready1 !== 1'b1 || contact1 !== 1'b0) begin errs++; $display("FAIL reset_ready_contact: got %b%b expected 10", ready1, contact1); end
            vecs++;
            if (hori0 !== 4'hF) begin errs++; $display("FAIL reset_hori0 vert=%h: got %h expected f", vert0, hori0); end
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        vecs++;
        if (ready1 !== 1'b1 || contact1 !== 1'b0) begin errs++; $display("FAIL post_reset: got ready=%b contact=%b expected 1 0", ready1, contact1); end
    endtask

    task automatic test_clean_edges();
        vert0 = 4'b1011;
        cmd_key = 4'h6; cmd_press = 1'b1; valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        vecs++;
        if (contact0 !== 1'b0 || ready0 !== 1'b1) begin errs++; $display("FAIL clean_edge_n: got contact=%b ready=%b expected 0 1", contact0, ready0); end
        tick();
        vecs++;
        if (contact0 !== 1'b1) begin errs++; $display("FAIL clean_contact: got %b expected 1", contact0); end
        vecs++;
        if (hori0 !== 4'b1101) begin errs++; $display("FAIL clean_row: got %b expected 1101", hori0); end
        vert0 = 4'b1110;
        #1;
        vecs++;
        if (hori0 !== 4'hF) begin errs++; $display("FAIL clean_other_col: got %b expected 1111", hori0); end
        vert0 = 4'b1011;
        cmd_press = 1'b0; valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        tick();
        vecs++;
        if (contact0 !== 1'b0 || hori0 !== 4'hF || ready0 !== 1'b1) begin
            errs++; $display("FAIL clean_release: got contact=%b hori=%b ready=%b expected 0 1111 1", contact0, hori0, ready0);
        end
    endtask

    task automatic test_bounce_press();
        int low;
        int toggles;
        logic prev;
        vert1 = 4'b1110;
        cmd_key = 4'h0; cmd_press = 1'b1; valid1 = 1'b1;
        tick();
        valid1 = 1'b0;
        vecs++;
        if (ready1 !== 1'b0 || contact1 !== 1'b0) begin errs++; $display("FAIL press_edge_n: got ready=%b contact=%b expected 0 0", ready1, contact1); end
        low = 1; toggles = 0; prev = contact1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            model = step(model);
            vecs++;
            if (contact1 !== model[0]) begin errs++; $display("FAIL bounce_dn_contact k=%0d: got %b expected %b", k, contact1, model[0]); end
            if (contact1 !== prev) toggles++;
            prev = contact1;
            if (ready1 === 1'b0) low++;
        end
        vecs++;
        if (low != 16 || ready1 !== 1'b1) begin errs++; $display("FAIL bounce_dn_ready_low: got %0d cycles ready=%b expected 16 1", low, ready1); end
        vecs++;
        if (toggles < 1) begin errs++; $display("FAIL bounce_dn_toggle: got %0d toggles expected >=1", toggles); end
        tick();
        vecs++;
        if (contact1 !== 1'b1 || hori1 !== 4'b1110) begin errs++; $display("FAIL held: got contact=%b hori=%b expected 1 1110", contact1, hori1); end
        cmd_key = 4'hF; cmd_press = 1'b1; valid1 = 1'b1;
        tick();
        valid1 = 1'b0;
        vecs++;
        if (ready1 !== 1'b1 || hori1 !== 4'b1110) begin errs++; $display("FAIL held_press_ignored: got ready=%b hori=%b expected 1 1110", ready1, hori1); end
        vert1 = 4'b0111;
        #1;
        vecs++;
        if (hori1 !== 4'hF) begin errs++; $display("FAIL held_key_unchanged: got %b expected 1111", hori1); end
        vert1 = 4'b1110;
    endtask

    task automatic test_release();
        cmd_press = 1'b0; valid1 = 1'b1;
        tick();
        valid1 = 1'b0;
        vecs++;
        if (ready1 !== 1'b0) begin errs++; $display("FAIL release_ready: got %b expected 0", ready1); end
        for (int k = 1; k <= 16; k++) begin
            tick();
            model = step(model);
            vecs++;
            if (contact1 !== model[0] || ready1 !== (k == 16)) begin
                errs++; $display("FAIL bounce_up k=%0d: got contact=%b ready=%b expected %b %b", k, contact1, ready1, model[0], (k == 16));
            end
        end
        tick();
        vecs++;
        if (contact1 !== 1'b0 || hori1 !== 4'hF) begin errs++; $display("FAIL released: got contact=%b hori=%b expected 0 1111", contact1, hori1); end
        cmd_press = 1'b0; valid1 = 1'b1;
        #1;
        vecs++;
        if (ready1 !== 1'b1) begin errs++; $display("FAIL idle_release_ready: got %b expected 1", ready1); end
        tick();
        valid1 = 1'b0;
        vecs++;
        if (ready1 !== 1'b1 || contact1 !== 1'b0 || hori1 !== 4'hF) begin
            errs++; $display("FAIL idle_release: got ready=%b contact=%b hori=%b expected 1 0 1111", ready1, contact1, hori1);
        end
    endtask

    task automatic test_stall();
        cmd_key = 4'h0; cmd_press = 1'b1; valid1 = 1'b1;
        tick();
        cmd_press = 1'b0;
        vecs++;
        if (ready1 !== 1'b0) begin errs++; $display("FAIL stall_ready: got %b expected 0", ready1); end
        for (int k = 1; k <= 16; k++) begin
            tick();
            model = step(model);
            vecs++;
            if (contact1 !== model[0] || ready1 !== (k == 16)) begin
                errs++; $display("FAIL stall_dn k=%0d: got contact=%b ready=%b expected %b %b", k, contact1, ready1, model[0], (k == 16));
            end
        end
        tick();
        valid1 = 1'b0;
        vecs++;
        if (ready1 !== 1'b0 || contact1 !== 1'b1) begin errs++; $display("FAIL stall_accept: got ready=%b contact=%b expected 0 1", ready1, contact1); end
        for (int k = 1; k <= 16; k++) begin
            tick();
            model = step(model);
            vecs++;
            if (contact1 !== model[0] || ready1 !== (k == 16)) begin
                errs++; $display("FAIL stall_up k=%0d: got contact=%b ready=%b expected %b %b", k, contact1, ready1, model[0], (k == 16));
            end
        end
        tick();
        vecs++;
        if (contact1 !== 1'b0 || hori1 !== 4'hF) begin errs++; $display("FAIL stall_idle: got contact=%b hori=%b expected 0 1111", contact1, hori1); end
    endtask

    task automatic test_reset_mid_bounce();
        bit found;
        vert1 = 4'b1101;
        cmd_key = 4'h5; cmd_press = 1'b1; valid1 = 1'b1;
        tick();
        valid1 = 1'b0;
        found = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            model = step(model);
            vecs++;
            if (contact1 !== model[0]) begin errs++; $display("FAIL mid_contact k=%0d: got %b expected %b", k, contact1, model[0]); end
            if (model[0]) begin
                found = 1'b1;
                break;
            end
        end
        vecs++;
        if (!found) begin
            errs++; $display("FAIL mid_no_contact: got no contact in 15 cycles expected one");
        end else if (hori1 !== 4'b1101) begin
            errs++; $display("FAIL mid_row: got %b expected 1101", hori1);
        end
        reset = 1'b1;
        #1;
        vecs++;
        if (hori1 !== 4'hF || contact1 !== 1'b0 || ready1 !== 1'b1) begin
            errs++; $display("FAIL async_reset: got hori=%b contact=%b ready=%b expected 1111 0 1", hori1, contact1, ready1);
        end
        model = 8'hA5;
        @(negedge clk);
        reset = 1'b0;
        tick();
        vecs++;
        if (ready1 !== 1'b1 || contact1 !== 1'b0 || hori1 !== 4'hF) begin
            errs++; $display("FAIL after_reset: got ready=%b contact=%b hori=%b expected 1 0 1111", ready1, contact1, hori1);
        end
        cmd_key = 4'h5; cmd_press = 1'b1; valid1 = 1'b1;
        tick();
        valid1 = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            tick();
            model = step(model);
            vecs++;
            if (contact1 !== model[0]) begin errs++; $display("FAIL reseeded k=%0d: got %b expected %b", k, contact1, model[0]); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_edges();
        test_bounce_press();
        test_release();
        test_stall();
        test_reset_mid_bounce();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
